// File: rtl/alu_control_fsm_if.sv
// alu_control_fsm_if: the control bundle between the multi-cycle control
// unit (master) and the 16-bit datapath (slave). The datapath supplies the
// opcode and the ALU status flags; the controller returns every mux select,
// write enable and debug status.
interface alu_control_fsm_if #(
    parameter int OPW    = 4,
    parameter int ALUOPW = 3
);
    logic [OPW-1:0]    opcode;
    logic              Zero;
    logic              AltB;
    logic              PCWrite;
    logic              IorD;
    logic              MemRead;
    logic              MemWrite;
    logic              IRWrite;
    logic              RegWrite;
    logic              MemtoReg;
    logic              ALUSrcA;
    logic [1:0]        ALUSrcB;
    logic [ALUOPW-1:0] ALUOp;
    logic [1:0]        PCSource;
    logic              halted;
    logic              illegal;
    logic [3:0]        state;

    modport master (
        input  opcode, Zero, AltB,
        output PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite, MemtoReg,
               ALUSrcA, ALUSrcB, ALUOp, PCSource, halted, illegal, state
    );

    modport slave (
        output opcode, Zero, AltB,
        input  PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite, MemtoReg,
               ALUSrcA, ALUSrcB, ALUOp, PCSource, halted, illegal, state
    );
endinterface

// File: rtl/alu_control_fsm.sv
// alu_control_fsm: multi-cycle control unit for the 16-bit processor.
// Steps each instruction through fetch, decode, execute, memory and
// writeback, driving the ALU op select, datapath muxes and write enables.
// Optional build macro ILLEGAL_TRAP_EN: when defined, an illegal opcode
// traps into a sticky TRAP state; otherwise it executes as a 2-cycle NOP.
module alu_control_fsm #(
    parameter int OPW    = 4,
    parameter int ALUOPW = 3
) (
    input  logic              CLK,
    input  logic              Reset,
    alu_control_fsm_if.master bus
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        EXEC_I   = 4'd3,
        MEM_ADDR = 4'd4,
        MEM_RD   = 4'd5,
        MEM_WB   = 4'd6,
        MEM_WR   = 4'd7,
        WB       = 4'd8,
        BRANCH   = 4'd9,
        JUMP     = 4'd10,
        HALT     = 4'd11
`ifdef ILLEGAL_TRAP_EN
        , TRAP   = 4'd12
`endif
    } state_e;

    typedef struct packed {
        logic              pc_write;
        logic              iord;
        logic              mem_read;
        logic              mem_write;
        logic              ir_write;
        logic              reg_write;
        logic              mem_to_reg;
        logic              alu_src_a;
        logic [1:0]        alu_src_b;
        logic [ALUOPW-1:0] alu_op;
        logic [1:0]        pc_source;
        logic              halted;
        logic              illegal;
    } ctrl_t;

    localparam logic [OPW-1:0] OP_RMAX = OPW'(5);
    localparam logic [OPW-1:0] OP_ADDI = OPW'(6);
    localparam logic [OPW-1:0] OP_LW   = OPW'(7);
    localparam logic [OPW-1:0] OP_SW   = OPW'(8);
    localparam logic [OPW-1:0] OP_BEQ  = OPW'(9);
    localparam logic [OPW-1:0] OP_BLT  = OPW'(10);
    localparam logic [OPW-1:0] OP_JMP  = OPW'(12);
    localparam logic [OPW-1:0] OP_HALT = OPW'(15);

    localparam logic [ALUOPW-1:0] ALU_ADD = ALUOPW'(2);
    localparam logic [ALUOPW-1:0] ALU_SUB = ALUOPW'(3);
    localparam logic [ALUOPW-1:0] ALU_SLT = ALUOPW'(5);

    state_e         state_q;
    state_e         state_d;
    ctrl_t          ctl;
    logic [OPW-1:0] op;

    assign op = bus.opcode;

    // State register; reset returns to FETCH, abandoning any instruction in flight.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and Moore control decode; Reset masks every output so no enable leaks out during reset.
    always_comb begin
        state_d = state_q;
        ctl     = '0;
        case (state_q)
            FETCH: begin
                ctl.mem_read  = 1'b1;
                ctl.ir_write  = 1'b1;
                ctl.alu_src_b = 2'd1;
                ctl.alu_op    = ALU_ADD;
                ctl.pc_write  = 1'b1;
                state_d       = DECODE;
            end
            DECODE: begin
                // PC + imm8 is precomputed here so BRANCH can take it from ALUOut.
                ctl.alu_src_b = 2'd2;
                ctl.alu_op    = ALU_ADD;
                if (op <= OP_RMAX) begin
                    state_d = EXEC_R;
                end else begin
                    case (op)
                        OP_ADDI:       state_d = EXEC_I;
                        OP_LW, OP_SW:  state_d = MEM_ADDR;
                        OP_BEQ, OP_BLT: state_d = BRANCH;
                        OP_JMP:        state_d = JUMP;
                        OP_HALT:       state_d = HALT;
`ifdef ILLEGAL_TRAP_EN
                        default:       state_d = TRAP;
`else
                        default:       state_d = FETCH;
`endif
                    endcase
                end
            end
            EXEC_R: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_op    = ALUOPW'(op[2:0]);
                state_d       = WB;
            end
            EXEC_I: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = 2'd2;
                ctl.alu_op    = ALU_ADD;
                state_d       = WB;
            end
            WB: begin
                ctl.reg_write = 1'b1;
                state_d       = FETCH;
            end
            MEM_ADDR: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = 2'd2;
                ctl.alu_op    = ALU_ADD;
                state_d       = (op == OP_LW) ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                ctl.mem_read = 1'b1;
                ctl.iord     = 1'b1;
                state_d      = MEM_WB;
            end
            MEM_WB: begin
                ctl.reg_write  = 1'b1;
                ctl.mem_to_reg = 1'b1;
                state_d        = FETCH;
            end
            MEM_WR: begin
                ctl.mem_write = 1'b1;
                ctl.iord      = 1'b1;
                state_d       = FETCH;
            end
            BRANCH: begin
                // The only Mealy output: PCWrite follows the ALU flag for the branch kind.
                ctl.alu_src_a = 1'b1;
                ctl.pc_source = 2'd1;
                if (op == OP_BLT) begin
                    ctl.alu_op   = ALU_SLT;
                    ctl.pc_write = bus.AltB;
                end else begin
                    ctl.alu_op   = ALU_SUB;
                    ctl.pc_write = bus.Zero;
                end
                state_d = FETCH;
            end
            JUMP: begin
                ctl.pc_source = 2'd2;
                ctl.pc_write  = 1'b1;
                state_d       = FETCH;
            end
            HALT: begin
                ctl.halted = 1'b1;
                state_d    = HALT;
            end
`ifdef ILLEGAL_TRAP_EN
            TRAP: begin
                ctl.illegal = 1'b1;
                state_d     = TRAP;
            end
`endif
            default: begin
                state_d = FETCH;
            end
        endcase
        if (Reset) begin
            ctl = '0;
        end
    end

    assign bus.PCWrite  = ctl.pc_write;
    assign bus.IorD     = ctl.iord;
    assign bus.MemRead  = ctl.mem_read;
    assign bus.MemWrite = ctl.mem_write;
    assign bus.IRWrite  = ctl.ir_write;
    assign bus.RegWrite = ctl.reg_write;
    assign bus.MemtoReg = ctl.mem_to_reg;
    assign bus.ALUSrcA  = ctl.alu_src_a;
    assign bus.ALUSrcB  = ctl.alu_src_b;
    assign bus.ALUOp    = ctl.alu_op;
    assign bus.PCSource = ctl.pc_source;
    assign bus.halted   = ctl.halted;
    assign bus.illegal  = ctl.illegal;
    assign bus.state    = Reset ? 4'd0 : state_q;

endmodule

// File: tb/tb_alu_control_fsm.sv
// tb_alu_control_fsm: scoreboard bench for alu_control_fsm. Each issued
// instruction is expanded by a reference model into its expected per-cycle
// control words, queued, and compared by an independent negedge monitor.
module tb_alu_control_fsm;

    typedef struct packed {
        logic       pc_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_source;
        logic       halted;
        logic       illegal;
        logic [3:0] state;
    } ctrl_t;

    typedef struct {
        ctrl_t      exp;
        logic [3:0] op;
        int         step;
    } sb_entry_t;

`ifdef ILLEGAL_TRAP_EN
    localparam bit TRAP_ON = 1'b1;
`else
    localparam bit TRAP_ON = 1'b0;
`endif

    logic CLK   = 1'b0;
    logic Reset = 1'b1;

    alu_control_fsm_if #(.OPW(4), .ALUOPW(3)) bus ();

    alu_control_fsm #(.OPW(4), .ALUOPW(3)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    sb_entry_t sb[$];
    ctrl_t     trace[$];
    ctrl_t     act;
    int        n_checks = 0;
    int        n_pass   = 0;

    assign act = {bus.PCWrite, bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite,
                  bus.RegWrite, bus.MemtoReg, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp,
                  bus.PCSource, bus.halted, bus.illegal, bus.state};

    function automatic ctrl_t blank(input logic [3:0] st);
        ctrl_t c;
        c       = '0;
        c.state = st;
        return c;
    endfunction

    function automatic bit is_illegal(input logic [3:0] op);
        return (op == 4'hB) || (op == 4'hD) || (op == 4'hE);
    endfunction

    // Expected cycle-by-cycle control words for one instruction, straight from the opcode table.
    function automatic void build_trace(input logic [3:0] op, input logic z,
                                        input logic lt, input int hold);
        ctrl_t c;
        trace.delete();
        c = blank(4'd0);
        c.mem_read = 1'b1; c.ir_write = 1'b1; c.alu_src_b = 2'd1;
        c.alu_op = 3'd2; c.pc_write = 1'b1;
        trace.push_back(c);
        c = blank(4'd1);
        c.alu_src_b = 2'd2; c.alu_op = 3'd2;
        trace.push_back(c);
        if (op <= 4'd5) begin
            c = blank(4'd2); c.alu_src_a = 1'b1; c.alu_op = op[2:0];
            trace.push_back(c);
            c = blank(4'd8); c.reg_write = 1'b1;
            trace.push_back(c);
        end else if (op == 4'd6) begin
            c = blank(4'd3); c.alu_src_a = 1'b1; c.alu_src_b = 2'd2; c.alu_op = 3'd2;
            trace.push_back(c);
            c = blank(4'd8); c.reg_write = 1'b1;
            trace.push_back(c);
        end else if (op == 4'd7 || op == 4'd8) begin
            c = blank(4'd4); c.alu_src_a = 1'b1; c.alu_src_b = 2'd2; c.alu_op = 3'd2;
            trace.push_back(c);
            if (op == 4'd7) begin
                c = blank(4'd5); c.mem_read = 1'b1; c.iord = 1'b1;
                trace.push_back(c);
                c = blank(4'd6); c.reg_write = 1'b1; c.mem_to_reg = 1'b1;
                trace.push_back(c);
            end else begin
                c = blank(4'd7); c.mem_write = 1'b1; c.iord = 1'b1;
                trace.push_back(c);
            end
        end else if (op == 4'h9 || op == 4'hA) begin
            c = blank(4'd9); c.alu_src_a = 1'b1; c.pc_source = 2'd1;
            c.alu_op   = (op == 4'h9) ? 3'd3 : 3'd5;
            c.pc_write = (op == 4'h9) ? z : lt;
            trace.push_back(c);
        end else if (op == 4'hC) begin
            c = blank(4'd10); c.pc_source = 2'd2; c.pc_write = 1'b1;
            trace.push_back(c);
        end else if (op == 4'hF) begin
            c = blank(4'd11); c.halted = 1'b1;
            for (int i = 0; i < hold; i++) trace.push_back(c);
        end else if (TRAP_ON) begin
            c = blank(4'd12); c.illegal = 1'b1;
            for (int i = 0; i < hold; i++) trace.push_back(c);
        end
    endfunction

    task automatic resetCycle();
        Reset = 1'b1;
        sb.push_back('{blank(4'd0), 4'h0, 0});
        @(posedge CLK); #1;
        Reset = 1'b0;
    endtask

    // Issue one instruction; abort_at > 0 asserts Reset after that many cycles.
    task automatic applyStimulus(input logic [3:0] op, input logic z, input logic lt,
                                 input int hold, input int abort_at);
        int n;
        bit stuck;
        build_trace(op, z, lt, hold);
        n     = trace.size();
        stuck = (op == 4'hF) || (TRAP_ON && is_illegal(op));
        if (abort_at > 0 && abort_at < n) n = abort_at;
        bus.opcode = op;
        bus.Zero   = z;
        bus.AltB   = lt;
        for (int i = 0; i < n; i++) sb.push_back('{trace[i], op, i + 1});
        repeat (n) begin
            @(posedge CLK); #1;
        end
        if (n < trace.size() || stuck) resetCycle();
    endtask

    task automatic checkOutput(input sb_entry_t e);
        n_checks++;
        if (act === e.exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL ctrl op=%h step=%0d got=%h expected=%h (state got=%0d expected=%0d)",
                     e.op, e.step, act, e.exp, act.state, e.exp.state);
        end
    endtask

    // Monitor: every cycle with a queued expectation is compared mid-cycle.
    always @(negedge CLK) begin
        sb_entry_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            checkOutput(e);
        end
    end

    initial begin
        int op_r;
        int abort_r;
        Reset      = 1'b1;
        bus.opcode = 4'h0;
        bus.Zero   = 1'b0;
        bus.AltB   = 1'b0;
        @(posedge CLK); #1;
        repeat (2) begin
            sb.push_back('{blank(4'd0), 4'h0, 0});
            @(posedge CLK); #1;
        end
        Reset = 1'b0;

        applyStimulus(4'h2, 1'b0, 1'b0, 0, 0);
        applyStimulus(4'h7, 1'b0, 1'b0, 0, 0);
        applyStimulus(4'h9, 1'b1, 1'b0, 0, 0);
        applyStimulus(4'h9, 1'b0, 1'b1, 0, 0);
        applyStimulus(4'hA, 1'b0, 1'b1, 0, 0);
        applyStimulus(4'hA, 1'b1, 1'b0, 0, 0);
        applyStimulus(4'hF, 1'b0, 1'b0, 20, 0);
        applyStimulus(4'hB, 1'b0, 1'b0, 5, 0);
        applyStimulus(4'h8, 1'b0, 1'b0, 0, 0);
        applyStimulus(4'h6, 1'b0, 1'b0, 0, 0);
        applyStimulus(4'hC, 1'b0, 1'b0, 0, 0);
        applyStimulus(4'h5, 1'b0, 1'b0, 0, 0);
        applyStimulus(4'h7, 1'b0, 1'b0, 0, 3);

        for (int k = 0; k < 300; k++) begin
            op_r    = int'($urandom_range(0, 15));
            abort_r = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 4)) : 0;
            applyStimulus(op_r[3:0], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          int'($urandom_range(1, 4)), abort_r);
        end

        @(negedge CLK); #1;
        n_checks++;
        if (sb.size() == 0) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL drain got=%0d expected=0 pending entries", sb.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
